// File: rtl/if_pipe_stage_if.sv
// Purpose: valid/ready handshake bundle carrying one fetched instruction and its PC.
// Ports:   valid/pc/instr flow master -> slave, ready flows slave -> master.
// Usage:   instantiate once on the fetch side and once on the decode side of the stage.
interface if_pipe_stage_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  logic               valid;
  logic               ready;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr;

  modport master (output valid, output pc, output instr, input ready);
  modport slave  (input valid, input pc, input instr, output ready);
endinterface

// File: rtl/if_pipe_stage.sv
// Purpose: fetch-to-decode pipeline register with optional two-entry skid buffer, freeze and flush.
// Latency: one cycle from acceptance on up to valid on dn; one instruction per cycle sustained.
// Backpressure: SKID=1 absorbs two entries and drops up.ready from registered state only;
//               SKID=0 forwards dn.ready combinationally into up.ready.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   freeze, flush  stall both sides / discard all held and incoming entries (flush wins)
//   up             slave side from fetch (in_valid/in_ready/pc_in/instruction_in)
//   dn             master side to decode (out_valid/out_ready/pc/instruction)
//   occupancy      entries held (0..2)
//   flush_drops    saturating count of valid entries discarded by flush
module if_pipe_stage #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int SKID    = 1,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic                 flush,
  if_pipe_stage_if.slave       up,
  if_pipe_stage_if.master      dn,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     flush_drops
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               m_valid;
  logic [PC_W-1:0]    m_pc;
  logic [INSTR_W-1:0] m_instr;
  logic               s_valid;
  logic [PC_W-1:0]    s_pc;
  logic [INSTR_W-1:0] s_instr;

  logic               acc;
  logic               dep;
  logic [1:0]         drop_inc;
  logic [CNT_W:0]     drop_sum;
  logic [CNT_W-1:0]   drops_next;

  assign dn.valid  = m_valid & ~freeze;
  assign dn.pc     = m_pc;
  assign dn.instr  = m_instr;

  // With the skid buffer, ready only looks at the skid slot so there is no
  // combinational path from dn.ready; without it, a full main entry can still
  // accept when decode drains it in the same cycle.
  assign up.ready  = (SKID != 0) ? (~s_valid & ~freeze)
                                 : ((~m_valid | dn.ready) & ~freeze);

  assign acc       = up.valid & up.ready;
  assign dep       = dn.valid & dn.ready;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

  // Saturating drop counter: everything held plus anything accepted this cycle.
  always_comb begin
    drop_inc   = {1'b0, m_valid} + {1'b0, s_valid} + {1'b0, acc};
    drop_sum   = {1'b0, flush_drops} + {{(CNT_W-1){1'b0}}, drop_inc};
    drops_next = drop_sum[CNT_W-1:0];
    if (drop_sum > {1'b0, CNT_MAX}) begin
      drops_next = CNT_MAX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid     <= 1'b0;
      m_pc        <= '0;
      m_instr     <= '0;
      s_valid     <= 1'b0;
      s_pc        <= '0;
      s_instr     <= '0;
      flush_drops <= '0;
    end else if (flush) begin
      m_valid     <= 1'b0;
      m_pc        <= '0;
      m_instr     <= '0;
      s_valid     <= 1'b0;
      s_pc        <= '0;
      s_instr     <= '0;
      flush_drops <= drops_next;
    end else if (!freeze) begin
      if (SKID != 0) begin
        if (dep && s_valid) begin
          // Skid slot moves forward; acceptance cannot coincide (ready was low).
          m_valid <= 1'b1;
          m_pc    <= s_pc;
          m_instr <= s_instr;
          s_valid <= 1'b0;
          s_pc    <= '0;
          s_instr <= '0;
        end else if (dep && acc) begin
          m_pc    <= up.pc;
          m_instr <= up.instr;
        end else if (dep) begin
          // Drained with nothing behind it: present a bubble.
          m_valid <= 1'b0;
          m_pc    <= '0;
          m_instr <= '0;
        end else if (acc && !m_valid) begin
          m_valid <= 1'b1;
          m_pc    <= up.pc;
          m_instr <= up.instr;
        end else if (acc) begin
          // Decode is stalled with main full: park the new entry in the skid slot.
          s_valid <= 1'b1;
          s_pc    <= up.pc;
          s_instr <= up.instr;
        end
      end else begin
        if (acc) begin
          m_valid <= 1'b1;
          m_pc    <= up.pc;
          m_instr <= up.instr;
        end else if (dep) begin
          m_valid <= 1'b0;
          m_pc    <= '0;
          m_instr <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_pipe_stage.sv
// Purpose: checks a SKID=1/CNT_W=16 stage and a SKID=0/CNT_W=2 stage driven by identical inputs.
// Latency: directed scenarios first, then randomized traffic against a queue-based model.
// Backpressure: out_ready, freeze, flush and rst are all randomized in the second phase.
module tb_if_pipe_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] pc_in;
  logic [31:0] instruction_in;
  logic        out_ready;
  logic        freeze;
  logic        flush;

  logic [1:0]  occ1;
  logic [1:0]  occ0;
  logic [15:0] drops1;
  logic [1:0]  drops0;

  int checks   = 0;
  int failures = 0;

  if_pipe_stage_if #(.PC_W(32), .INSTR_W(32)) up1 ();
  if_pipe_stage_if #(.PC_W(32), .INSTR_W(32)) dn1 ();
  if_pipe_stage_if #(.PC_W(32), .INSTR_W(32)) up0 ();
  if_pipe_stage_if #(.PC_W(32), .INSTR_W(32)) dn0 ();

  assign up1.valid = in_valid;
  assign up1.pc    = pc_in;
  assign up1.instr = instruction_in;
  assign dn1.ready = out_ready;
  assign up0.valid = in_valid;
  assign up0.pc    = pc_in;
  assign up0.instr = instruction_in;
  assign dn0.ready = out_ready;

  if_pipe_stage #(.PC_W(32), .INSTR_W(32), .SKID(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .up(up1), .dn(dn1), .occupancy(occ1), .flush_drops(drops1)
  );

  if_pipe_stage #(.PC_W(32), .INSTR_W(32), .SKID(0), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .up(up0), .dn(dn0), .occupancy(occ0), .flush_drops(drops0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: FIFO of {pc, instr} per stage ----------------
  logic [63:0] q1[$];
  logic [63:0] q0[$];
  int          c1 = 0;
  int          c0 = 0;

  initial begin : model
    bit          ov1, ir1, acc1, dep1;
    bit          ov0, ir0, acc0, dep0;
    logic [63:0] head1, head0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        q1.delete();
        q0.delete();
        c1 = 0;
        c0 = 0;
      end
      ov1   = (q1.size() > 0) && !freeze;
      ir1   = (q1.size() < 2) && !freeze;
      head1 = (q1.size() > 0) ? q1[0] : 64'd0;
      ov0   = (q0.size() > 0) && !freeze;
      ir0   = ((q0.size() == 0) || out_ready) && !freeze;
      head0 = (q0.size() > 0) ? q0[0] : 64'd0;

      chk("m1_out_valid", {63'd0, dn1.valid}, {63'd0, ov1});
      chk("m1_in_ready",  {63'd0, up1.ready}, {63'd0, ir1});
      chk("m1_pc_instr",  {dn1.pc, dn1.instr}, head1);
      chk("m1_occupancy", {62'd0, occ1}, 64'(q1.size()));
      chk("m1_drops",     {48'd0, drops1}, 64'(c1));
      chk("m0_out_valid", {63'd0, dn0.valid}, {63'd0, ov0});
      chk("m0_in_ready",  {63'd0, up0.ready}, {63'd0, ir0});
      chk("m0_pc_instr",  {dn0.pc, dn0.instr}, head0);
      chk("m0_occupancy", {62'd0, occ0}, 64'(q0.size()));
      chk("m0_drops",     {62'd0, drops0}, 64'(c0));

      acc1 = in_valid && ir1;
      dep1 = ov1 && out_ready;
      acc0 = in_valid && ir0;
      dep0 = ov0 && out_ready;

      @(posedge clk);
      if (!rst) begin
        if (flush) begin
          c1 = c1 + q1.size() + int'(acc1);
          if (c1 > 65535) c1 = 65535;
          c0 = c0 + q0.size() + int'(acc0);
          if (c0 > 3) c0 = 3;
          q1.delete();
          q0.delete();
        end else if (!freeze) begin
          if (dep1) void'(q1.pop_front());
          if (acc1) q1.push_back({pc_in, instruction_in});
          if (dep0) void'(q0.pop_front());
          if (acc0) q0.push_back({pc_in, instruction_in});
        end
      end
    end
  end

  // ---------------- stimulus and literal expectations ----------------
  task automatic drive(input bit iv, input logic [31:0] p, input bit ordy,
                       input bit frz, input bit fl, input bit r);
    @(negedge clk);
    rst            = r;
    in_valid       = iv;
    pc_in          = p;
    instruction_in = p ^ 32'hA5A5_0000;
    out_ready      = ordy;
    freeze         = frz;
    flush          = fl;
    #3;
  endtask

  initial begin : stim
    rst = 1'b0; in_valid = 1'b0; pc_in = '0; instruction_in = '0;
    out_ready = 1'b0; freeze = 1'b0; flush = 1'b0;

    // Reset state (asynchronous, observed before any clock edge in reset).
    drive(0, 0, 0, 0, 0, 1);
    chk("rst_out_valid", {63'd0, dn1.valid}, 64'd0);
    chk("rst_pc",        {32'd0, dn1.pc}, 64'd0);
    chk("rst_occ",       {62'd0, occ1}, 64'd0);
    chk("rst_drops",     {48'd0, drops1}, 64'd0);
    chk("rst_in_ready1", {63'd0, up1.ready}, 64'd1);
    chk("rst_in_ready0", {63'd0, up0.ready}, 64'd1);
    drive(0, 0, 1, 0, 0, 0);

    // Stream pc 0,4,8,12 with instructions 0xE3A00001..04.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid       = (i < 4);
      pc_in          = 32'(i * 4);
      instruction_in = 32'hE3A0_0001 + 32'(i);
      out_ready      = 1'b1;
      #3;
      if (i > 0) begin
        chk("stream_pc",    {32'd0, dn1.pc}, 64'((i - 1) * 4));
        chk("stream_instr", {32'd0, dn1.instr}, 64'(32'hE3A0_0001 + 32'(i - 1)));
        chk("stream_occ",   {62'd0, occ1}, 64'd1);
        chk("stream_pc0",   {32'd0, dn0.pc}, 64'((i - 1) * 4));
      end
    end

    // Back-pressure with the skid buffer.
    drive(1, 32'h100, 1, 0, 0, 0);
    drive(1, 32'h104, 0, 0, 0, 0);
    chk("bp_in_ready1_open", {63'd0, up1.ready}, 64'd1);
    chk("bp_in_ready0_comb", {63'd0, up0.ready}, 64'd0);
    drive(1, 32'h108, 0, 0, 0, 0);
    chk("bp_occ_full",  {62'd0, occ1}, 64'd2);
    chk("bp_ready_low", {63'd0, up1.ready}, 64'd0);
    chk("bp_pc_held",   {32'd0, dn1.pc}, 64'h100);
    drive(1, 32'h108, 1, 0, 0, 0);
    chk("bp_drain0", {32'd0, dn1.pc}, 64'h100);
    chk("bp_ready0_replace", {63'd0, up0.ready}, 64'd1);
    drive(1, 32'h108, 1, 0, 0, 0);
    chk("bp_drain1", {32'd0, dn1.pc}, 64'h104);
    drive(0, 0, 1, 0, 0, 0);
    chk("bp_drain2", {32'd0, dn1.pc}, 64'h108);
    drive(0, 0, 1, 0, 0, 0);
    chk("bp_bubble", {31'd0, dn1.valid, dn1.pc}, 64'd0);

    // Freeze for three cycles mid-stream.
    drive(1, 32'h200, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h204, 1, 1, 0, 0);
      chk("frz_out_valid", {63'd0, dn1.valid}, 64'd0);
      chk("frz_in_ready",  {62'd0, up1.ready, up0.ready}, 64'd0);
      chk("frz_pc",        {32'd0, dn1.pc}, 64'h200);
    end
    drive(1, 32'h204, 1, 0, 0, 0);
    chk("frz_resume0", {31'd0, dn1.valid, dn1.pc}, 64'h1_0000_0200);
    drive(0, 0, 1, 0, 0, 0);
    chk("frz_resume1", {32'd0, dn1.pc}, 64'h204);
    drive(0, 0, 1, 0, 0, 0);

    // Flush with a full skid buffer (in_ready is low, so only the two held entries drop).
    drive(1, 32'h300, 0, 0, 0, 0);
    drive(1, 32'h304, 0, 0, 0, 0);
    drive(1, 32'h308, 0, 0, 1, 0);
    chk("fl_pre_occ", {62'd0, occ1}, 64'd2);
    drive(0, 0, 0, 0, 0, 0);
    chk("fl_bubble", {31'd0, dn1.valid, dn1.pc}, 64'd0);
    chk("fl_instr",  {32'd0, dn1.instr}, 64'd0);
    chk("fl_occ",    {62'd0, occ1}, 64'd0);
    chk("fl_drops1", {48'd0, drops1}, 64'd2);
    chk("fl_drops0", {62'd0, drops0}, 64'd1);

    // Flush and freeze together: flush wins, freeze still blocks acceptance.
    drive(1, 32'h400, 1, 0, 0, 0);
    drive(1, 32'h404, 1, 1, 1, 0);
    drive(0, 0, 1, 0, 0, 0);
    chk("ff_occ",    {62'd0, occ1}, 64'd0);
    chk("ff_drops1", {48'd0, drops1}, 64'd3);
    chk("ff_drops0", {62'd0, drops0}, 64'd2);

    // Saturation on the 2-bit counter: each flush drops the incoming entry.
    drive(1, 32'h408, 1, 0, 1, 0);
    drive(1, 32'h40C, 1, 0, 1, 0);
    drive(0, 0, 1, 0, 0, 0);
    chk("sat_drops0", {62'd0, drops0}, 64'd3);
    chk("sat_drops1", {48'd0, drops1}, 64'd5);

    // SKID=0 replaces main every cycle while decode keeps up.
    drive(1, 32'h500, 1, 0, 0, 0);
    drive(1, 32'h504, 1, 0, 0, 0);
    chk("s0_ready", {63'd0, up0.ready}, 64'd1);
    drive(1, 32'h508, 1, 0, 0, 0);
    chk("s0_pc", {32'd0, dn0.pc}, 64'h504);

    // Reset mid-operation clears everything immediately.
    drive(1, 32'h600, 0, 0, 0, 0);
    drive(1, 32'h604, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    chk("rst_mid_occ",   {62'd0, occ1}, 64'd0);
    chk("rst_mid_drops", {46'd0, drops1, drops0}, 64'd0);
    drive(0, 0, 0, 0, 1, 1);
    chk("rst_flush_drops", {48'd0, drops1}, 64'd0);
    drive(0, 0, 1, 0, 0, 0);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 199) == 0);
    end

    drive(0, 0, 1, 0, 0, 0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
